// File: rtl/calc_pkg.sv
// Shared key codes and FSM state type for the calculator keypad entry logic.
package calc_pkg;

   localparam logic [3:0] KEY_MAIS    = 4'hA;
   localparam logic [3:0] KEY_IGUAL   = 4'hB;
   localparam logic [3:0] KEY_CLR     = 4'hC;
   localparam logic [3:0] KEY_MAX_DIG = 4'h9;

   typedef enum logic [2:0] {
      ESP_A = 3'd0,
      TEM_A = 3'd1,
      ESP_B = 3'd2,
      TEM_B = 3'd3,
      FIM   = 3'd4
   } estado_t;

   function automatic logic eh_digito(input logic [3:0] code);
      return code <= KEY_MAX_DIG;
   endfunction

endpackage

// File: rtl/deb_tecla.sv
// Key debounce and press lock: one accept pulse after DEB_CYCLES identical samples,
// then locked (busy) until key_valid is seen low.
module deb_tecla #(
   parameter int DEB_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       key_valid_i,
   input  logic [3:0] key_code_i,
   output logic       accept_o,
   output logic [3:0] code_o,
   output logic       busy_o
);

   localparam logic [3:0] CNT_ULT = 4'(DEB_CYCLES - 1);
   localparam logic [3:0] CNT_MAX = 4'(DEB_CYCLES);

   logic [3:0] cnt_q, cnt_d;
   logic [3:0] code_q, code_d;
   logic       lock_q, lock_d;
   logic       acc_q, acc_d;

   always_comb begin
      cnt_d  = cnt_q;
      code_d = code_q;
      lock_d = lock_q;
      acc_d  = 1'b0;
      if (!key_valid_i) begin
         cnt_d  = '0;
         lock_d = 1'b0;
      end else if (lock_q) begin
         // held after acceptance: counter stays saturated, code changes ignored
         cnt_d = cnt_q;
      end else if (cnt_q == '0 || key_code_i != code_q) begin
         code_d = key_code_i;
         cnt_d  = 4'd1;
      end else if (cnt_q == CNT_ULT) begin
         cnt_d  = CNT_MAX;
         acc_d  = 1'b1;
         lock_d = 1'b1;
      end else begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q  <= '0;
         code_q <= '0;
         lock_q <= 1'b0;
         acc_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         code_q <= code_d;
         lock_q <= lock_d;
         acc_q  <= acc_d;
      end
   end

   assign accept_o = acc_q;
   assign code_o   = code_q;
   assign busy_o   = lock_q;

endmodule

// File: rtl/entrada_calc.sv
// Calculator keypad entry: debounced keys drive a five-state operand/operator FSM.
// Outputs change one edge after the debounce accept pulse.
module entrada_calc
   import calc_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [3:0] D,
   output logic       sel,
   output logic       soma,
   output logic       clr,
   output logic       busy
);

   logic       acc;
   logic [3:0] acc_code;

   estado_t    state_q, state_d;
   logic [3:0] d_q, d_d;
   logic       sel_q, sel_d;
   logic       soma_q, soma_d;
   logic       clr_q, clr_d;

   deb_tecla #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_i      (CLK),
      .rst_n_i    (reset),
      .key_valid_i(key_valid),
      .key_code_i (key_code),
      .accept_o   (acc),
      .code_o     (acc_code),
      .busy_o     (busy)
   );

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_q <= ESP_A;
         d_q     <= '0;
         sel_q   <= 1'b0;
         soma_q  <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         sel_q   <= sel_d;
         soma_q  <= soma_d;
         clr_q   <= clr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      sel_d   = sel_q;
      soma_d  = 1'b0;
      clr_d   = 1'b0;
      if (acc) begin
         if (acc_code == KEY_CLR) begin
            clr_d   = 1'b1;
            d_d     = '0;
            sel_d   = 1'b0;
            state_d = ESP_A;
         end else begin
            // keys not handled in the current state fall through unchanged
            unique case (state_q)
               ESP_A: if (eh_digito(acc_code)) begin
                  d_d     = acc_code;
                  sel_d   = 1'b0;
                  state_d = TEM_A;
               end
               TEM_A: if (eh_digito(acc_code)) begin
                  d_d = acc_code;
               end else if (acc_code == KEY_MAIS) begin
                  sel_d   = 1'b1;
                  state_d = ESP_B;
               end
               ESP_B: if (eh_digito(acc_code)) begin
                  d_d     = acc_code;
                  state_d = TEM_B;
               end
               TEM_B: if (eh_digito(acc_code)) begin
                  d_d = acc_code;
               end else if (acc_code == KEY_IGUAL) begin
                  soma_d  = 1'b1;
                  state_d = FIM;
               end
               FIM: if (eh_digito(acc_code)) begin
                  d_d     = acc_code;
                  sel_d   = 1'b0;
                  state_d = TEM_A;
               end
               default: state_d = ESP_A;
            endcase
         end
      end
   end

   assign D    = d_q;
   assign sel  = sel_q;
   assign soma = soma_q;
   assign clr  = clr_q;

endmodule

// File: tb/tb_entrada_calc.sv
// Bench for entrada_calc: keypress table, directed corner sequences and random keys vs a model.
module tb_entrada_calc;
   import calc_pkg::*;

   localparam int DEB = 4;

   logic       CLK;
   logic       reset;
   logic       key_valid;
   logic [3:0] key_code;
   logic [3:0] D;
   logic       sel, soma, clr, busy;

   entrada_calc #(.DEB_CYCLES(DEB)) dut (
      .CLK      (CLK),
      .reset    (reset),
      .key_valid(key_valid),
      .key_code (key_code),
      .D        (D),
      .sel      (sel),
      .soma     (soma),
      .clr      (clr),
      .busy     (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   estado_t    m_st;
   logic [3:0] m_d;
   logic       m_sel, m_soma, m_clr;
   int         m_run;
   logic [3:0] m_code;
   bit         m_done, m_pend;
   logic [3:0] m_pcode;

   int soma_cnt, clr_cnt, acc_cnt, busy_cnt;
   bit saw_two;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_key(input logic [3:0] c);
      if (c == KEY_CLR) begin
         m_clr = 1'b1; m_d = 4'h0; m_sel = 1'b0; m_st = ESP_A;
      end else if (c <= 4'h9) begin
         m_d = c;
         if (m_st == ESP_A || m_st == FIM) begin m_sel = 1'b0; m_st = TEM_A; end
         else if (m_st == ESP_B) m_st = TEM_B;
      end else if (c == KEY_MAIS && m_st == TEM_A) begin
         m_sel = 1'b1; m_st = ESP_B;
      end else if (c == KEY_IGUAL && m_st == TEM_B) begin
         m_soma = 1'b1; m_st = FIM;
      end
   endtask

   // one rising edge worth of model behaviour, from the sampled inputs
   task automatic model_step(input logic r, input logic v, input logic [3:0] c);
      if (!r) begin
         m_st = ESP_A; m_d = 4'h0; m_sel = 1'b0; m_soma = 1'b0; m_clr = 1'b0;
         m_run = 0; m_done = 1'b0; m_pend = 1'b0; m_code = 4'h0;
      end else begin
         m_soma = 1'b0; m_clr = 1'b0;
         if (m_pend) model_key(m_pcode);
         m_pend = 1'b0;
         if (!v) begin
            m_run = 0; m_done = 1'b0;
         end else begin
            if (m_run > 0 && c == m_code) m_run = (m_run < DEB) ? m_run + 1 : m_run;
            else begin m_run = 1; m_code = c; end
            if (!m_done && m_run == DEB) begin
               m_pend = 1'b1; m_pcode = c; m_done = 1'b1;
            end
         end
      end
   endtask

   task automatic cyc(input logic v, input logic [3:0] c, input logic r);
      key_valid = v; key_code = c; reset = r;
      @(posedge CLK);
      model_step(r, v, c);
      #1;
      chk("model", {24'h0, D, sel, soma, clr, busy}, {24'h0, m_d, m_sel, m_soma, m_clr, m_done});
      if (D == 4'h2) saw_two = 1'b1;
      soma_cnt += int'(soma);
      clr_cnt  += int'(clr);
      busy_cnt += int'(busy);
      acc_cnt  += int'(dut.u_deb.acc_q);
   endtask

   typedef struct {
      logic [3:0] code;
      int         hold;
      logic [3:0] exp_d;
      logic       exp_sel;
      estado_t    exp_st;
      int         exp_soma;
      int         exp_clr;
   } vec_t;

   vec_t tbl [13];

   initial begin
      tbl[0]  = '{4'h3, 10, 4'h3, 1'b0, TEM_A, 0, 0};
      tbl[1]  = '{4'hA,  6, 4'h3, 1'b1, ESP_B, 0, 0};
      tbl[2]  = '{4'h5,  6, 4'h5, 1'b1, TEM_B, 0, 0};
      tbl[3]  = '{4'hB,  6, 4'h5, 1'b1, FIM,   1, 0};
      tbl[4]  = '{4'h7,  6, 4'h7, 1'b0, TEM_A, 0, 0};
      tbl[5]  = '{4'hA,  6, 4'h7, 1'b1, ESP_B, 0, 0};
      tbl[6]  = '{4'h5,  6, 4'h5, 1'b1, TEM_B, 0, 0};
      tbl[7]  = '{4'hC,  6, 4'h0, 1'b0, ESP_A, 0, 1};
      tbl[8]  = '{4'hB,  6, 4'h0, 1'b0, ESP_A, 0, 0};
      tbl[9]  = '{4'hE,  6, 4'h0, 1'b0, ESP_A, 0, 0};
      tbl[10] = '{4'hA,  6, 4'h0, 1'b0, ESP_A, 0, 0};
      tbl[11] = '{4'h8,  5, 4'h8, 1'b0, TEM_A, 0, 0};
      tbl[12] = '{4'h2,  4, 4'h2, 1'b0, TEM_A, 0, 0};

      soma_cnt = 0; clr_cnt = 0; acc_cnt = 0; busy_cnt = 0; saw_two = 1'b0;
      key_valid = 1'b0; key_code = 4'h0; reset = 1'b0;
      repeat (3) cyc(1'b0, 4'h0, 1'b0);
      chk("rst_D", 32'(D), 32'h0);
      chk("rst_ctl", {29'h0, sel, soma, clr}, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_state", 32'(dut.state_q), 32'(ESP_A));
      cyc(1'b0, 4'h0, 1'b1);

      foreach (tbl[i]) begin
         soma_cnt = 0; clr_cnt = 0;
         repeat (tbl[i].hold) cyc(1'b1, tbl[i].code, 1'b1);
         repeat (2) cyc(1'b0, tbl[i].code, 1'b1);
         chk($sformatf("tbl%0d_D", i), 32'(D), 32'(tbl[i].exp_d));
         chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].exp_sel));
         chk($sformatf("tbl%0d_state", i), 32'(dut.state_q), 32'(tbl[i].exp_st));
         chk($sformatf("tbl%0d_soma_pulses", i), 32'(soma_cnt), 32'(tbl[i].exp_soma));
         chk($sformatf("tbl%0d_clr_pulses", i), 32'(clr_cnt), 32'(tbl[i].exp_clr));
      end

      // long hold: a single accept, busy from the 4th sample until release
      acc_cnt = 0; busy_cnt = 0;
      repeat (50) cyc(1'b1, 4'h4, 1'b1);
      chk("hold_busy_cycles", 32'(busy_cnt), 32'(50 - DEB + 1));
      cyc(1'b0, 4'h4, 1'b1);
      chk("hold_accepts", 32'(acc_cnt), 32'd1);
      chk("hold_busy_release", 32'(busy), 32'h0);
      chk("hold_D", 32'(D), 32'h4);

      // code change mid-debounce: 2 never reaches D, 7 lands on the 5th edge of 7
      saw_two = 1'b0;
      repeat (2) cyc(1'b1, 4'h2, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         cyc(1'b1, 4'h7, 1'b1);
         if (k == DEB) chk("chg_before", 32'(D), 32'h4);
         if (k == DEB + 1) chk("chg_after", 32'(D), 32'h7);
      end
      repeat (2) cyc(1'b0, 4'h7, 1'b1);
      chk("chg_no_two", 32'(saw_two), 32'h0);

      // short glitch
      busy_cnt = 0;
      repeat (3) cyc(1'b1, 4'h3, 1'b1);
      repeat (2) cyc(1'b0, 4'h3, 1'b1);
      chk("glitch_busy", 32'(busy_cnt), 32'h0);
      chk("glitch_D", 32'(D), 32'h7);

      // reset mid-debounce with the key held through release
      repeat (2) cyc(1'b1, 4'h9, 1'b1);
      repeat (2) cyc(1'b1, 4'h9, 1'b0);
      chk("mid_rst_out", {24'h0, D, sel, soma, clr, busy}, 32'h0);
      chk("mid_rst_state", 32'(dut.state_q), 32'(ESP_A));
      for (int k = 1; k <= 6; k++) begin
         cyc(1'b1, 4'h9, 1'b1);
         if (k == DEB) chk("post_rst_before", 32'(D), 32'h0);
         if (k == DEB + 1) chk("post_rst_after", 32'(D), 32'h9);
      end
      repeat (2) cyc(1'b0, 4'h9, 1'b1);

      // random key traffic against the model
      for (int s = 0; s < 400; s++) begin
         logic [3:0] c;
         int hold, gap;
         c    = (($urandom % 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         hold = $urandom_range(1, 8);
         gap  = $urandom_range(0, 2);
         if ($urandom_range(0, 39) == 0) begin
            repeat ($urandom_range(1, 2)) cyc(1'($urandom), c, 1'b0);
         end
         repeat (hold) cyc(1'b1, c, 1'b1);
         repeat (gap) cyc(1'b0, c, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
